// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// Compile-time switch: DESER_PARITY_EN appends one even-parity bit to every word.
package deser_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam bit DEF_MSB_FIRST = 1'b1;

`ifdef DESER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // bit_cnt must be able to hold WIDTH itself (reached in parity mode)
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_if.sv
// Serial-in / parallel-out handshake bundle for the deserializer.
// Optional DESER_PARITY_EN adds the parity_err status line.
interface deser_if
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CW = cnt_width(WIDTH);

    logic             flush;
    logic             din_serial;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout_parallel;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_cnt;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output flush, din_serial, din_valid, dout_ready,
        input  din_ready, dout_parallel, dout_valid, bit_cnt
`ifdef DESER_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  flush, din_serial, din_valid, dout_ready,
        output din_ready, dout_parallel, dout_valid, bit_cnt
`ifdef DESER_PARITY_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/deser_out_reg.sv
// Single-entry output holding register with valid/ready handshake.
// The word is only replaced on load; upstream never loads while a word is stuck.
module deser_out_reg #(
    parameter int WIDTH    = 8,
    parameter int PAR_BITS = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH+PAR_BITS-1:0] load_data,
    input  logic                      ready,
    output logic                      valid,
    output logic [WIDTH+PAR_BITS-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter with a skid-free single-entry output register.
// Compile-time switch: DESER_PARITY_EN (WIDTH data bits + one even-parity bit per word).
module deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input logic    clk,
    input logic    rst,
    deser_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int OW = WIDTH + PAR_BITS;
`ifdef DESER_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             din_bit;
    logic             last_bit;
    logic             ready;
    logic             accept;
    logic             complete;
    logic             out_valid;
    logic [OW-1:0]    load_data;
    logic [OW-1:0]    out_data;

    // Only the word-completing bit can be blocked; earlier bits never touch the output register.
    assign last_bit = (cnt == LAST_CNT);
    assign ready    = !(out_valid && !bus.dout_ready && last_bit);
    assign accept   = bus.din_valid && ready;
    assign complete = accept && last_bit && !bus.flush;
    assign din_bit  = bus.din_serial & bus.din_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], din_bit};
        else           shreg_next = {din_bit, shreg[WIDTH-1:1]};
    end

`ifdef DESER_PARITY_EN
    assign load_data = {(^shreg) ^ din_bit, shreg};
`else
    assign load_data = shreg_next;
`endif

    // NOTE: the shift register is a plain register, not a memory, so it is cleared by rst and flush.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (last_bit) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= shreg_next;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    deser_out_reg #(
        .WIDTH    (WIDTH),
        .PAR_BITS (PAR_BITS)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (load_data),
        .ready     (bus.dout_ready),
        .valid     (out_valid),
        .data      (out_data)
    );

    assign bus.din_ready     = ready;
    assign bus.dout_valid    = out_valid;
    assign bus.dout_parallel = out_data[WIDTH-1:0];
    assign bus.bit_cnt       = cnt;
`ifdef DESER_PARITY_EN
    assign bus.parity_err    = out_data[WIDTH];
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: one MSB-first and one LSB-first instance share stimulus.
// Honours DESER_PARITY_EN by appending an even-parity bit to each streamed word.
module tb_deserializer;
    import deser_pkg::*;

    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic din_serial;
    logic din_valid;
    logic dout_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    deser_if #(.WIDTH(W)) bus_m ();
    deser_if #(.WIDTH(W)) bus_l ();

    assign bus_m.flush      = flush;
    assign bus_m.din_serial = din_serial;
    assign bus_m.din_valid  = din_valid;
    assign bus_m.dout_ready = dout_ready;
    assign bus_l.flush      = flush;
    assign bus_l.din_serial = din_serial;
    assign bus_l.din_valid  = din_valid;
    assign bus_l.dout_ready = dout_ready;

    deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit j of the stream for word v: data MSB first, then (parity mode) the even-parity bit
    function automatic logic bit_of(input logic [7:0] v, input int j);
        if (j < W) return v[7-j];
        return ^v;
    endfunction

    task automatic put_bit(input logic b);
        din_valid  = 1'b1;
        din_serial = b;
        step();
    endtask

    task automatic send_word(input logic [7:0] v);
        for (int j = 0; j < NB; j++) put_bit(bit_of(v, j));
        din_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hB2, 8'hB2, 8'h4D};
        vecs[1] = '{8'h01, 8'h01, 8'h80};
        vecs[2] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[3] = '{8'h6E, 8'h6E, 8'h76};
        vecs[4] = '{8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF};

        rst = 1'b1; flush = 1'b0; din_serial = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus_m.dout_valid, 0);
        check("rst_data", bus_m.dout_parallel, 0);
        check("rst_cnt", bus_m.bit_cnt, 0);
        check("rst_ready", bus_m.din_ready, 1);

        // Back-to-back words at one bit per cycle, consumer always ready
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < NB; j++) begin
                check("b2b_din_ready", bus_m.din_ready, 1);
                put_bit(bit_of(vecs[i].data, j));
                if (j == 0 && i > 0) check("b2b_valid_drop", bus_m.dout_valid, 0);
                if (j < NB - 1) check("b2b_cnt", bus_m.bit_cnt, j + 1);
            end
            check("b2b_valid", bus_m.dout_valid, 1);
            check("b2b_data_msb", bus_m.dout_parallel, vecs[i].exp_m);
            check("b2b_data_lsb", bus_l.dout_parallel, vecs[i].exp_l);
            check("b2b_cnt_wrap", bus_m.bit_cnt, 0);
        end
        din_valid = 1'b0;
        step();
        check("b2b_tail_valid", bus_m.dout_valid, 0);

        // X on din_serial while din_valid is low must not matter
        din_serial = 1'bx;
        step();
        step();
        check("x_cnt", bus_m.bit_cnt, 0);
        send_word(8'hB2);
        check("x_data_msb", bus_m.dout_parallel, 8'hB2);
        check("x_data_lsb", bus_l.dout_parallel, 8'h4D);
        step();

        // Backpressure: A5 held, last bit of 3C stalls until consumer takes A5
        dout_ready = 1'b0;
        send_word(8'hA5);
        check("bp_first_valid", bus_m.dout_valid, 1);
        check("bp_first_data", bus_m.dout_parallel, 8'hA5);
        for (int j = 0; j < NB - 1; j++) begin
            check("bp_din_ready_hi", bus_m.din_ready, 1);
            put_bit(bit_of(8'h3C, j));
        end
        din_valid  = 1'b1;
        din_serial = bit_of(8'h3C, NB - 1);
        #1;
        check("bp_din_ready_lo", bus_m.din_ready, 0);
        step();
        step();
        check("bp_hold_cnt", bus_m.bit_cnt, NB - 1);
        check("bp_hold_data_msb", bus_m.dout_parallel, 8'hA5);
        check("bp_hold_data_lsb", bus_l.dout_parallel, 8'hA5);
        check("bp_hold_valid", bus_m.dout_valid, 1);
        dout_ready = 1'b1;
        #1;
        check("bp_din_ready_comb", bus_m.din_ready, 1);
        step();
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        check("bp_second_valid", bus_m.dout_valid, 1);
        check("bp_second_data_msb", bus_m.dout_parallel, 8'h3C);
        check("bp_second_data_lsb", bus_l.dout_parallel, 8'h3C);
        check("bp_second_cnt", bus_m.bit_cnt, 0);
        step();
        check("bp_second_hold", bus_m.dout_parallel, 8'h3C);
        dout_ready = 1'b1;
        step();
        check("bp_drain_valid", bus_m.dout_valid, 0);

        // Flush with a coincident bit: bit dropped, no leftover in the next word
        for (int j = 0; j < 5; j++) put_bit(1'b1);
        check("fl_cnt5", bus_m.bit_cnt, 5);
        flush = 1'b1;
        put_bit(1'b1);
        flush = 1'b0;
        din_valid = 1'b0;
        check("fl_cnt0", bus_m.bit_cnt, 0);
        check("fl_no_word", bus_m.dout_valid, 0);
        send_word(8'hFF);
        check("fl_next_valid", bus_m.dout_valid, 1);
        check("fl_next_data", bus_m.dout_parallel, 8'hFF);
        step();

        // Flush leaves a pending output word untouched
        dout_ready = 1'b0;
        send_word(8'h81);
        for (int j = 0; j < 3; j++) put_bit(1'b0);
        flush = 1'b1;
        din_valid = 1'b0;
        step();
        flush = 1'b0;
        check("flp_cnt", bus_m.bit_cnt, 0);
        check("flp_valid", bus_m.dout_valid, 1);
        check("flp_data_lsb", bus_l.dout_parallel, 8'h81);

        // Reset mid-word with a pending word, also colliding with a valid bit
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        send_word(8'h6E);
        for (int j = 0; j < 3; j++) put_bit(1'b1);
        check("rmw_cnt3", bus_m.bit_cnt, 3);
        check("rmw_valid", bus_m.dout_valid, 1);
        rst = 1'b1;
        put_bit(1'b1);
        rst = 1'b0;
        din_valid = 1'b0;
        check("rmw_valid0", bus_m.dout_valid, 0);
        check("rmw_data0", bus_m.dout_parallel, 0);
        check("rmw_cnt0", bus_m.bit_cnt, 0);

`ifdef DESER_PARITY_EN
        // Parity: 81 has even data parity, so parity bit 0 is good and 1 is bad
        dout_ready = 1'b1;
        for (int j = 0; j < W; j++) put_bit(bit_of(8'h81, j));
        put_bit(1'b0);
        check("par_good_data", bus_m.dout_parallel, 8'h81);
        check("par_good_err", bus_m.parity_err, 0);
        for (int j = 0; j < W; j++) put_bit(bit_of(8'h81, j));
        put_bit(1'b1);
        din_valid = 1'b0;
        check("par_bad_err", bus_m.parity_err, 1);
        check("par_bad_err_lsb", bus_l.parity_err, 1);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in dout_parallel[WIDTH-1]; 0 = first received bit lands in dout_parallel[0].
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 flush  input  1  discard the partial word in the shift register.
REQ-007 din_serial  input  1  serial data bit.
REQ-008 din_valid  input  1  din_serial is valid this cycle.
REQ-009 din_ready  output  1  the block accepts a bit this cycle.
REQ-010 dout_parallel  output  WIDTH  assembled word.
REQ-011 dout_valid  output  1  dout_parallel holds an unconsumed word.
REQ-012 dout_ready  input  1  the consumer takes the word this cycle.
REQ-013 bit_cnt  output  $clog2(WIDTH+1)  number of bits accepted in the current partial word.

Function
REQ-014 A bit SHALL be accepted only on a cycle where din_valid && din_ready is true.
REQ-015 Each accepted bit SHALL shift into the shift register in the MSB_FIRST order and increment bit_cnt.
REQ-016 When the WIDTH-th data bit is accepted, the assembled word SHALL load the output register at that edge. dout_valid SHALL be high from the next cycle, giving 1-cycle latency from the last bit. bit_cnt SHALL return to 0.
REQ-017 A word SHALL be consumed on a cycle with dout_valid && dout_ready. If no new word loads at the same edge, dout_valid SHALL fall at that edge.
REQ-018 While dout_valid is high and dout_ready is low, dout_parallel SHALL hold stable.
REQ-019 din_ready SHALL be low only while the output register is full, dout_ready is low, and the next accepted bit would complete a word. This is a combinational path from dout_ready.
REQ-020 A word completion and a consumption on the same edge SHALL load the new word with dout_valid held high; no word is lost and no bubble is inserted.
REQ-021 Back-to-back words with din_valid held high and dout_ready held high SHALL sustain one bit per cycle with no stall.
REQ-022 flush SHALL clear the shift register and bit_cnt at the edge and leave the output register and dout_valid unaffected.
REQ-023 If flush and an accepted bit coincide, flush SHALL win and the bit SHALL be dropped.
REQ-024 din_serial SHALL be ignored when din_valid is low. X on din_serial with din_valid low SHALL not propagate.

Reset
REQ-025 On rst high at an edge, the block SHALL set dout_valid=0, dout_parallel=0, bit_cnt=0 and clear the shift register. If DESER_PARITY_EN is defined, parity_err=0.
REQ-026 Reset mid-word SHALL discard the partial word. Reset with a pending output word SHALL discard that word.
REQ-027 rst SHALL take priority over flush and over data acceptance.

Configuration
REQ-028 The macro DESER_PARITY_EN SHALL be the only compile-time feature switch.
REQ-029 With DESER_PARITY_EN defined, each word SHALL be WIDTH data bits followed by one even-parity bit. Word completion occurs on the parity bit, and bit_cnt counts up to WIDTH.
REQ-030 With DESER_PARITY_EN defined, an output port parity_err (1 bit) SHALL load alongside dout_parallel. It is 1 when the XOR of the data bits and the parity bit is 1, and it is held stable under the same rules as dout_parallel.
REQ-031 Without DESER_PARITY_EN, the parity_err port SHALL not exist and words SHALL be exactly WIDTH bits.

Structure
REQ-032 A shared package deser_pkg SHALL hold the WIDTH and MSB_FIRST default constants and a function for the bit_cnt width.
REQ-033 The output holding register with valid/ready SHALL be a sub-module named deser_out_reg. It is parameterised by WIDTH plus an optional parity_err bit.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, dout_ready=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dout_parallel=8'hB2, dout_valid high for 1 cycle, on the cycle after the 8th bit.
REQ-035 Same stream with MSB_FIRST=0 -> dout_parallel=8'h4D.
REQ-036 WIDTH=8, dout_ready=0, two words 8'hA5 then 8'h3C streamed -> din_ready falls before the 16th bit; 8'hA5 held. Raise dout_ready for 1 cycle -> 8'hA5 consumed, 3C's last bit accepted the same edge, 8'h3C valid the next cycle.
REQ-037 Accept 5 bits, assert flush together with a 6th bit, then stream 8'hFF -> bit_cnt 0 after flush; next word 8'hFF with no leftover bits.
REQ-038 Assert rst with bit_cnt=3 and dout_valid=1 -> next cycle dout_valid=0, dout_parallel=0, bit_cnt=0.
REQ-039 DESER_PARITY_EN defined; data 8'h81 with parity bit 0, then 8'h81 with parity bit 1 -> parity_err=0 on the first word and parity_err=1 on the second.
